// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate stage.
//
// Accepts a stream of NUM_INPUTS (activation, weight) pairs for one neuron.
// It accumulates their full-precision products and adds the neuron's bias.
// It then rescales the sum back to the operand Q format, applies ReLU with
// positive saturation, and emits one output per inference.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         synchronous active-low reset
//   start_i        begin a new inference (honoured only while idle)
//   in_valid_i     in_data_i / in_weight_i valid this cycle
//   in_ready_o     pair is accepted this cycle when in_valid_i is also high
//   in_data_i      signed activation (Q format, FRAC_BITS fractional bits)
//   in_weight_i    signed weight (same Q format)
//   weight_addr_o  index of the next pair expected (weight memory address)
//   bias_in_i      signed bias, held constant for the whole inference
//   busy_o         high whenever an inference is in progress
//   out_valid_o    one-cycle pulse qualifying out_data_o
//   out_data_o     ReLU'd, saturated result; held until the next out_valid_o

module neuron_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_INPUTS = 784,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [DATA_WIDTH-1:0] in_weight_i,
  output logic [CNT_WIDTH-1:0]  weight_addr_o,
  input  logic [DATA_WIDTH-1:0] bias_in_i,
  output logic                  busy_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    ACT   = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_INPUTS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = DATA_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic signed [ACC_WIDTH-1:0]    scaled;
  logic [DATA_WIDTH-1:0]          sat_val;

  // Full-precision product keeps 2*FRAC_BITS fractional bits; the bias is
  // shifted up by FRAC_BITS so it lines up with that binary point.
  assign prod     = $signed(in_data_i) * $signed(in_weight_i);
  assign prod_ext = {{(ACC_WIDTH - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH - DATA_WIDTH - FRAC_BITS){bias_in_i[DATA_WIDTH-1]}},
                     bias_in_i, {FRAC_BITS{1'b0}}};

  // Arithmetic shift floors toward minus infinity, which is what ReLU wants:
  // any negative sum, however small, clamps to zero.
  assign scaled = acc_q >>> FRAC_BITS;

  always_comb begin
    sat_val = scaled[DATA_WIDTH-1:0];
    if (scaled < 0) begin
      sat_val = '0;
    end else if (scaled > SAT_MAX) begin
      sat_val = OUT_MAX;
    end
  end

  // State, accumulator, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state logic. The accumulator register doubles as the biased-sum
  // register in BIAS, so ACT reads the final sum straight from acc_q.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end

      ACCUM: begin
        if (in_valid_i) begin
          acc_d = acc_q + prod_ext;
          if (cnt_q == LAST_IDX) begin
            // Counter (and weight address) rewinds as we leave ACCUM.
            cnt_d   = '0;
            state_d = BIAS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = ACT;
      end

      ACT: begin
        out_data_d  = sat_val;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_o    = (state_q == ACCUM);
  assign busy_o        = (state_q != IDLE);
  assign weight_addr_o = cnt_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac (NUM_INPUTS reduced to 4).
// The driver pushes expected results into a queue; an independent monitor
// pops and compares whenever out_valid is seen.
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int N  = 4;
  localparam int AW = 40;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic [DW-1:0] inWeight;
  logic [CW-1:0] weightAddr;
  logic [DW-1:0] biasIn;
  logic          busy;
  logic          outValid;
  logic [DW-1:0] outData;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t expQ[$];
  int   outCycles[$];

  logic [DW-1:0] stimA[N];
  logic [DW-1:0] stimW[N];
  int            stimGap[N];
  logic [DW-1:0] biasVal;

  neuron_mac #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB),
    .NUM_INPUTS(N),
    .ACC_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_i      (start),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .in_data_i    (inData),
    .in_weight_i  (inWeight),
    .weight_addr_o(weightAddr),
    .bias_in_i    (biasIn),
    .busy_o       (busy),
    .out_valid_o  (outValid),
    .out_data_o   (outData)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp transfers and output pulses.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Reference model: dot product plus bias in plain integer arithmetic,
  // rescaled by floor division and clamped to [0, 2^(DW-1)-1].
  function automatic logic [DW-1:0] refModel();
    longint sum;
    longint scaled;
    longint maxPos;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      sum += longint'($signed(stimA[i])) * longint'($signed(stimW[i]));
    end
    sum += longint'($signed(biasVal)) * (longint'(1) << FB);
    scaled = sum >>> FB;
    maxPos = (longint'(1) << (DW - 1)) - 1;
    if (scaled < 0) return '0;
    if (scaled > maxPos) return DW'(maxPos);
    return DW'(scaled);
  endfunction

  // Monitor: every output pulse must match the oldest outstanding expectation
  // in both value and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rstN === 1'b1 && outValid === 1'b1) begin
      outCycles.push_back(cycle);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected out_valid: got out_data 0x%0h at cycle %0d, expected no pulse",
                 outData, cycle);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_data", 32'(outData), 32'(e.data));
        checkOutput("out_valid cycle", 32'(cycle), 32'(e.cyc));
      end
    end
  end

  task automatic sendPair(input int idx, output int lastEdge);
    bit ok;
    inValid  = 1'b1;
    inData   = stimA[idx];
    inWeight = stimW[idx];
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (inReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready timeout: got in_ready 0 for 20 cycles, expected 1");
    end
    checkOutput("weight_addr", 32'(weightAddr), 32'(idx));
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    lastEdge = cycle;
  endtask

  task automatic bubble(input int idx);
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("weight_addr bubble", 32'(weightAddr), 32'(idx));
    checkOutput("in_ready bubble", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // One inference. expOverride < 0 uses the reference model.
  task automatic applyStimulus(input logic [DW-1:0] bias, input int expOverride,
                               input int startMidAt, input int abortAt,
                               input bit backToBack);
    int lastEdge;
    logic [DW-1:0] expVal;
    biasVal = bias;
    biasIn  = bias;
    lastEdge = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == abortAt) begin
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort in_ready", 32'(inReady), 32'd0);
        checkOutput("abort out_valid", 32'(outValid), 32'd0);
        checkOutput("abort out_data", 32'(outData), 32'd0);
        checkOutput("abort weight_addr", 32'(weightAddr), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        return;
      end
      for (int g = 0; g < stimGap[i]; g++) bubble(i);
      if (i == startMidAt) start = 1'b1;
      sendPair(i, lastEdge);
      start = 1'b0;
    end
    expVal = (expOverride < 0) ? refModel() : DW'(expOverride);
    expQ.push_back('{data: expVal, cyc: lastEdge + 2});
    @(negedge clk);
    checkOutput("in_ready after last", 32'(inReady), 32'd0);
    checkOutput("busy after last", 32'(busy), 32'd1);
    checkOutput("weight_addr rewind", 32'(weightAddr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready in ACT", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    if (backToBack) return;
    @(negedge clk);
    checkOutput("busy at out_valid", 32'(busy), 32'd0);
    checkOutput("in_ready at out_valid", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic loadCase1();
    for (int i = 0; i < N; i++) begin
      stimA[i]   = 16'h0100;
      stimW[i]   = 16'h0080;
      stimGap[i] = 0;
    end
  endtask

  initial begin
    int waitCnt;
    rstN     = 1'b0;
    start    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inWeight = '0;
    biasIn   = '0;
    biasVal  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset in_ready", 32'(inReady), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset out_data", 32'(outData), 32'd0);
    checkOutput("reset weight_addr", 32'(weightAddr), 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Basic accumulate: 4 * (1.0 * 0.5) + 0.25 = 2.25.
    loadCase1();
    applyStimulus(16'h0040, 16'h0240, -1, -1, 1'b0);

    // Negative sum clamps to zero: 4 * -1.0 + 1.0 = -3.0.
    for (int i = 0; i < N; i++) begin
      stimA[i] = 16'h0100;
      stimW[i] = 16'hFF00;
    end
    applyStimulus(16'h0100, 16'h0000, -1, -1, 1'b0);

    // Large positive sum saturates.
    for (int i = 0; i < N; i++) begin
      stimA[i] = 16'h7FFF;
      stimW[i] = 16'h7FFF;
    end
    applyStimulus(16'h0000, 16'h7FFF, -1, -1, 1'b0);

    // Bubbles: in_valid pattern 1,0,0,1,1,0,1.
    loadCase1();
    stimGap[1] = 2;
    stimGap[3] = 1;
    applyStimulus(16'h0040, 16'h0240, -1, -1, 1'b0);

    // start during ACCUM is ignored.
    loadCase1();
    applyStimulus(16'h0040, 16'h0240, 2, -1, 1'b0);

    // Back-to-back: start in the out_valid cycle.
    applyStimulus(16'h0040, 16'h0240, -1, -1, 1'b1);
    applyStimulus(16'h0040, 16'h0240, -1, -1, 1'b0);
    if (outCycles.size() >= 2) begin
      checkOutput("back-to-back spacing",
                  32'(outCycles[outCycles.size()-1] - outCycles[outCycles.size()-2]),
                  32'(N + 3));
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL back-to-back pulses: got %0d pulses, expected at least 2",
               outCycles.size());
    end

    // Reset after two transfers aborts; a fresh inference then works.
    applyStimulus(16'h0040, 16'h0240, -1, 2, 1'b0);
    applyStimulus(16'h0040, 16'h0240, -1, -1, 1'b0);

    // Randomized inferences checked against the reference model.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++) begin
        stimA[i]   = DW'($urandom);
        stimW[i]   = DW'($urandom);
        stimGap[i] = $urandom_range(0, 2);
      end
      applyStimulus(DW'($urandom), -1, -1, -1, (it < 19) ? bit'($urandom_range(0, 1)) : 1'b0);
    end

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 20) begin
      @(posedge clk);
      waitCnt++;
    end
    #1;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
